opu_rr_arbiter: RTL

//  Shares one Operation Processing Unit (OPU) among N_REQ server-side requesters.

---
 rtl/opu_rr_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/opu_rr_arbiter.sv
// Round-robin arbiter sharing one OPU among N_REQ requesters.
// Latches the winner's op_code/data, issues a single op_start pulse, then
// waits for op_done (or a timeout) and returns done/err to the winner.
module opu_rr_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 200,
  parameter int TO_W        = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [2*N_REQ-1:0] req_op_code,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic               err,
  output logic               busy,
  output logic [1:0]         op_code,
  output logic [7:0]         data,
  output logic               op_start,
  input  logic               op_done
);

  localparam int              PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             op_start_q, op_start_d;
  logic [1:0]       op_code_q, op_code_d;
  logic [7:0]       data_q, data_d;
  logic [TO_W-1:0]  timer_q, timer_d;
  logic [PTR_W-1:0] win_idx;

  // Index ptr+off reduced modulo N_REQ (off is in 1..N_REQ).
  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return PTR_W'(s);
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin search starting just after the last grant; walking the
  // offsets downwards lets the nearest requester overwrite farther ones.
  always_comb begin
    win_idx = ptr_q;
    for (int off = N_REQ; off >= 1; off--) begin
      if (req[wrap_idx(ptr_q, off)]) win_idx = wrap_idx(ptr_q, off);
    end
  end

  // State register plus all registered outputs; reset aborts silently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= PTR_W'(N_REQ - 1);
      gnt_q      <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      op_start_q <= 1'b0;
      op_code_q  <= '0;
      data_q     <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      op_start_q <= op_start_d;
      op_code_q  <= op_code_d;
      data_q     <= data_d;
      timer_q    <= timer_d;
    end
  end

  // Next-state logic: a granted transaction always runs to RELEASE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (op_done || (timer_q == TO_LAST)) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: values computed here appear one cycle later, so op_start
  // is raised on the grant edge and done/err on the edge leaving WAIT.
  always_comb begin
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    err_d      = 1'b0;
    op_start_d = 1'b0;
    op_code_d  = op_code_q;
    data_d     = data_q;
    timer_d    = timer_q;
    busy_d     = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (|req) begin
          ptr_d      = win_idx;
          gnt_d      = onehot(win_idx);
          op_code_d  = req_op_code[2*int'(win_idx) +: 2];
          data_d     = req_data[8*int'(win_idx) +: 8];
          timer_d    = '0;
          op_start_d = 1'b1;
        end
      end
      WAIT: begin
        // op_done takes priority over a coincident timeout
        if (op_done) begin
          done_d = gnt_q;
        end else if (timer_q == TO_LAST) begin
          done_d = gnt_q;
          err_d  = 1'b1;
        end else begin
          timer_d = timer_q + TO_W'(1);
        end
      end
      RELEASE: gnt_d = '0;
      default: ;
    endcase
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign op_start = op_start_q;
  assign op_code  = op_code_q;
  assign data     = data_q;

endmodule
